fft_sample_loader: RTL and testbench
====================================

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 Parameter SPI_WIDTH, default 8: sample word width.
REQ-002 Parameter N_SAMPLES, default 32: FFT frame length; SHALL be a power of 2, at least 4.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth for signals from the sclk domain.
REQ-004 clk  input  1  system clock; SHALL run at least 4x sclk.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 received_wd  input  1  sclk-domain word strobe; high for one sclk period.
REQ-007 sample_in  input  SPI_WIDTH  sclk-domain word; stable at least 7 sclk periods after the received_wd rise.
REQ-008 cs  input  1  SPI chip select, active low, asynchronous to clk.
REQ-009 fft_busy  input  1  FFT core is processing the read bank.
REQ-010 rd_addr  input  log2(N_SAMPLES)  FFT read address into the read bank.
REQ-011 rd_data  output  SPI_WIDTH  read-bank word at rd_addr, registered.
REQ-012 fft_start  output  1  one-clk pulse: read bank holds a new complete frame.
REQ-013 bank_sel  output  1  current write bank; read bank is ~bank_sel.
REQ-014 overflow  output  1  sticky flag: words were dropped.

Function
REQ-015 received_wd and cs SHALL each pass through a SYNC_STAGES flop chain before any use.
REQ-016 A word event is a 0->1 transition of synchronized received_wd; exactly one event per transition.
REQ-017 On each word event, sample_in SHALL be registered in the same clk cycle; no synchronization on the data bus.
REQ-018 Storage: two banks of N_SAMPLES x SPI_WIDTH (ping-pong); write pointer wr_ptr is log2(N_SAMPLES) bits.
REQ-019 FSM states: FILL and HOLD.
REQ-020 FILL: on each word event, write the registered word to bank[bank_sel][wr_ptr] one clk after capture, then increment wr_ptr.
REQ-021 FILL: a write to address N_SAMPLES-1 completes the frame; wr_ptr wraps to 0.
REQ-022 Frame complete with fft_busy low: toggle bank_sel and pulse fft_start in the next cycle; stay in FILL.
REQ-023 Frame complete with fft_busy high: go to HOLD.
REQ-024 HOLD: word events SHALL NOT write and SHALL set overflow.
REQ-025 HOLD -> FILL: in the first cycle with fft_busy low, toggle bank_sel and pulse fft_start; wr_ptr stays 0.
REQ-026 Synchronized cs high in FILL: reset wr_ptr to 0 and discard the partial frame; no fft_start.
REQ-027 Synchronized cs high in HOLD: no effect.
REQ-028 Word event and cs-high in the same cycle: cs wins; no write occurs.
REQ-029 Frame completion and fft_busy rising in the same cycle: fft_busy is sampled as high, so the FSM goes to HOLD.
REQ-030 rd_data SHALL equal bank[~bank_sel][rd_addr] one clk after rd_addr is applied.
REQ-031 Reads never conflict with writes to the same bank.
REQ-032 Latency: the received_wd rise at the FSM input is SYNC_STAGES+1 clk after the raw edge; the final word is in memory 1 clk later; fft_start follows 1 clk after that.
REQ-033 overflow clears only on reset.

Reset
REQ-034 reset_n low at a clk edge SHALL set state=FILL, wr_ptr=0, bank_sel=0, fft_start=0, overflow=0, rd_data=0, and all synchronizer flops=0.
REQ-035 Bank memory contents are not reset.
REQ-036 Reset during a partial frame discards the frame.
REQ-037 A stale received_wd high at reset release SHALL NOT create a word event until a fresh 0->1 transition.

Structure
REQ-038 The shared package SHALL hold: SPI_WIDTH, N_SAMPLES, the derived address width, and the FSM state enum.
REQ-039 One sub-module, bit_sync, SHALL implement the parameterized SYNC_STAGES flop chain; it is instantiated for received_wd and for cs.
REQ-040 Banks SHALL be inferable as block RAM: one write port and one registered read port.

Verification
REQ-041 Send 32 words 0x00..0x1F with fft_busy=0: exactly one fft_start pulse; bank_sel=1; reading rd_addr 0..31 returns 0x00..0x1F.
REQ-042 Hold fft_busy=1 across frame completion, then send 3 more words: FSM in HOLD; overflow=1; releasing fft_busy gives one fft_start; the read bank is unchanged.
REQ-043 Send 10 words, raise cs for 4 sclk, then send 32 words 0xA0..0xBF: one fft_start; read bank holds 0xA0..0xBF at addresses 0..31.
REQ-044 Assert reset_n=0 for 1 clk after 20 words, then send 32 words: one fft_start; bank_sel=1; overflow=0.
REQ-045 Hold received_wd high for 3 sclk periods: exactly one word written.
REQ-046 Back-to-back frames, 64 words 0x00..0x3F, fft_busy low: two fft_start pulses; bank_sel returns to 0; second read bank holds 0x20..0x3F.

Source files
------------

// File: rtl/fft_sample_loader_pkg.sv
// Shared definitions for the FFT sample loader: default frame geometry and FSM states.
package fft_sample_loader_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int N_SAMPLES = 32;
    localparam int ADDR_W    = $clog2(N_SAMPLES);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/fft_sample_loader_bit_sync.sv
// Parameterized flop-chain synchronizer for a single-bit signal entering the clk domain.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the chain; oldest sample is the output
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= (chain_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/fft_sample_loader.sv
// Ping-pong frame buffer between an SPI word receiver (sclk domain) and an FFT core.
// Words are written into the write bank; a full frame swaps banks and pulses fft_start.
module fft_sample_loader #(
    parameter int SPI_WIDTH   = fft_sample_loader_pkg::SPI_WIDTH,
    parameter int N_SAMPLES   = fft_sample_loader_pkg::N_SAMPLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         received_wd,
    input  logic [SPI_WIDTH-1:0]         sample_in,
    input  logic                         cs,
    input  logic                         fft_busy,
    input  logic [$clog2(N_SAMPLES)-1:0] rd_addr,
    output logic [SPI_WIDTH-1:0]         rd_data,
    output logic                         fft_start,
    output logic                         bank_sel,
    output logic                         overflow
);

    import fft_sample_loader_pkg::*;

    localparam int AW = $clog2(N_SAMPLES);
    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic                 wd_s;
    logic                 cs_s;
    logic                 wd_prev_q;
    logic                 armed_q;
    logic [CW-1:0]        settle_q;
    logic                 wd_evt;
    logic [SPI_WIDTH-1:0] word_q;
    logic                 wr_pend_q, wr_pend_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    state_e               state_q, state_d;
    logic                 bank_sel_q, bank_sel_d;
    logic                 fft_start_q, fft_start_d;
    logic                 overflow_q, overflow_d;
    logic                 mem_we;
    logic [SPI_WIDTH-1:0] rd_data_q;
    logic [SPI_WIDTH-1:0] mem [2*N_SAMPLES];

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_wd (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (received_wd),
        .q_o     (wd_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (cs),
        .q_o     (cs_s)
    );

    // Edge detector; arming waits until the chain holds post-reset samples and
    // has seen received_wd low, so a strobe still high at reset release is ignored
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            settle_q  <= '0;
        end else begin
            wd_prev_q <= wd_s;
            if (settle_q != CW'(SYNC_STAGES)) begin
                settle_q <= settle_q + 1'b1;
            end else if (!wd_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign wd_evt = armed_q & wd_s & ~wd_prev_q;

    // Capture the data bus on the event; it is stable long after the strobe, so no sync
    always_ff @(posedge clk) begin
        if (wd_evt) begin
            word_q <= sample_in;
        end
    end

    // FILL/HOLD control: write pending word, detect frame end, swap banks
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_pend_d   = 1'b0;
        bank_sel_d  = bank_sel_q;
        fft_start_d = 1'b0;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (cs_s) begin
                    // Deselect discards the partial frame, including a word in flight
                    wr_ptr_d = '0;
                end else begin
                    wr_pend_d = wd_evt;
                    if (wr_pend_q) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == AW'(N_SAMPLES - 1)) begin
                            if (fft_busy) begin
                                state_d = ST_HOLD;
                            end else begin
                                bank_sel_d  = ~bank_sel_q;
                                fft_start_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (wd_evt && !cs_s) begin
                    overflow_d = 1'b1;
                end
                if (!fft_busy) begin
                    state_d     = ST_FILL;
                    bank_sel_d  = ~bank_sel_q;
                    fft_start_d = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            wr_pend_q   <= 1'b0;
            bank_sel_q  <= 1'b0;
            fft_start_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_pend_q   <= wr_pend_d;
            bank_sel_q  <= bank_sel_d;
            fft_start_q <= fft_start_d;
            overflow_q  <= overflow_d;
        end
    end

    // Single write port into the current write bank
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{bank_sel_q, wr_ptr_q}] <= word_q;
        end
    end

    // Registered read port from the bank the FFT owns
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{~bank_sel_q, rd_addr}];
        end
    end

    assign rd_data   = rd_data_q;
    assign fft_start = fft_start_q;
    assign bank_sel  = bank_sel_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: stimulus pushes expected reads and
// expected fft_start pulses; monitors pop and compare as the DUT presents them.
module tb_fft_sample_loader;

    localparam int W  = 8;
    localparam int N  = 32;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         received_wd = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic         cs = 1'b0;
    logic         fft_busy = 1'b0;
    logic [4:0]   rd_addr = '0;
    logic [W-1:0] rd_data;
    logic         fft_start;
    logic         bank_sel;
    logic         overflow;

    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] rd_exp_q[$];
    logic         start_exp_q[$];
    logic         rd_issue = 1'b0;
    logic         rd_pend = 1'b0;

    fft_sample_loader #(
        .SPI_WIDTH   (W),
        .N_SAMPLES   (N),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .received_wd (received_wd),
        .sample_in   (sample_in),
        .cs          (cs),
        .fft_busy    (fft_busy),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .fft_start   (fft_start),
        .bank_sel    (bank_sel),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    always @(posedge clk) rd_pend <= rd_issue;

    // Monitor: registered read data and fft_start pulses against the queues
    always @(negedge clk) begin
        if (rd_pend && rd_exp_q.size() > 0) begin
            check("rd_data", {24'd0, rd_data}, {24'd0, rd_exp_q.pop_front()});
        end
        if (fft_start === 1'b1) begin
            if (start_exp_q.size() == 0) check("fft_start_spurious", {31'd0, fft_start}, 32'd0);
            else check("bank_sel_at_start", {31'd0, bank_sel}, {31'd0, start_exp_q.pop_front()});
        end
    end

    task automatic rd(input int a, input int e);
        @(negedge clk);
        rd_addr  = 5'(a);
        rd_issue = 1'b1;
        rd_exp_q.push_back(W'(e));
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic send_word(input int v);
        @(negedge clk);
        sample_in   = W'(v);
        received_wd = 1'b1;
        repeat (4) @(negedge clk);
        received_wd = 1'b0;
        repeat (28) @(negedge clk);
    endtask

    task automatic send_frame(input int base, input int n);
        for (int i = 0; i < n; i++) send_word(base + i);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a stale strobe held high across release
        received_wd = 1'b1;
        reset_n     = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_bank_sel", {31'd0, bank_sel}, 32'd0);
        check("rst_fft_start", {31'd0, fft_start}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        received_wd = 1'b0;
        settle();

        // One full frame, FFT idle
        start_exp_q.push_back(1'b1);
        send_frame(8'h00, 32);
        settle();
        check("t1_starts_seen", start_exp_q.size(), 32'd0);
        check("t1_bank_sel", {31'd0, bank_sel}, 32'd1);
        for (int i = 0; i < 32; i++) rd(i, i);

        // Frame completes while FFT busy, extra words dropped
        fft_busy = 1'b1;
        send_frame(8'h40, 32);
        send_frame(8'h60, 3);
        settle();
        check("t2_overflow", {31'd0, overflow}, 32'd1);
        check("t2_bank_sel_held", {31'd0, bank_sel}, 32'd1);
        check("t2_state_hold", {31'd0, dut.state_q}, 32'd1);
        rd(0, 8'h00);
        rd(31, 8'h1F);
        start_exp_q.push_back(1'b0);
        @(negedge clk);
        fft_busy = 1'b0;
        settle();
        check("t2_starts_seen", start_exp_q.size(), 32'd0);
        check("t2_bank_sel", {31'd0, bank_sel}, 32'd0);
        check("t2_overflow_sticky", {31'd0, overflow}, 32'd1);
        rd(0, 8'h40);
        rd(2, 8'h42);
        rd(31, 8'h5F);

        // Reset in mid-frame discards it and clears overflow
        send_frame(8'h80, 20);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
        check("t4_bank_sel_reset", {31'd0, bank_sel}, 32'd0);
        start_exp_q.push_back(1'b1);
        send_frame(8'hC0, 32);
        settle();
        check("t4_starts_seen", start_exp_q.size(), 32'd0);
        check("t4_bank_sel", {31'd0, bank_sel}, 32'd1);
        check("t4_overflow", {31'd0, overflow}, 32'd0);
        rd(0, 8'hC0);
        rd(19, 8'hD3);
        rd(31, 8'hDF);

        // Partial frame aborted by chip-select
        send_frame(8'h10, 10);
        @(negedge clk);
        cs = 1'b1;
        repeat (16) @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        start_exp_q.push_back(1'b0);
        send_frame(8'hA0, 32);
        settle();
        check("t3_starts_seen", start_exp_q.size(), 32'd0);
        check("t3_bank_sel", {31'd0, bank_sel}, 32'd0);
        for (int i = 0; i < 32; i++) rd(i, 8'hA0 + i);

        // Two back-to-back frames
        start_exp_q.push_back(1'b1);
        start_exp_q.push_back(1'b0);
        send_frame(8'h00, 64);
        settle();
        check("t6_starts_seen", start_exp_q.size(), 32'd0);
        check("t6_bank_sel", {31'd0, bank_sel}, 32'd0);
        for (int i = 0; i < 32; i++) rd(i, 8'h20 + i);

        // Strobe held high for three sclk periods yields a single word
        start_exp_q.push_back(1'b1);
        @(negedge clk);
        sample_in   = 8'h77;
        received_wd = 1'b1;
        repeat (12) @(negedge clk);
        received_wd = 1'b0;
        repeat (28) @(negedge clk);
        send_frame(8'h00, 31);
        settle();
        check("t5_starts_seen", start_exp_q.size(), 32'd0);
        check("t5_bank_sel", {31'd0, bank_sel}, 32'd1);
        rd(0, 8'h77);
        rd(1, 8'h00);
        rd(31, 8'h1E);

        repeat (5) @(negedge clk);
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);
        check("start_queue_drained", start_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
